// File: rtl/cmp_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM states,
// one-hot result encoding and the 7485-style cascade priority rule.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } cmp_state_e;

  // One-hot result {lt, eq, gt}
  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_LT = 3'b100;
  localparam cmp_res_t CMP_EQ = 3'b010;
  localparam cmp_res_t CMP_GT = 3'b001;

  // Cascade priority eq > lt > gt; no cascade input asserted means equal.
  function automatic cmp_res_t cascade_resolve(input logic lt, input logic eq, input logic gt);
    if (eq) begin
      return CMP_EQ;
    end else if (lt) begin
      return CMP_LT;
    end else if (gt) begin
      return CMP_GT;
    end else begin
      return CMP_EQ;
    end
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational magnitude compare of one DIGIT-bit digit pair (unsigned).
module digit_cmp #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt_c,
  output logic             eq_c,
  output logic             gt_c
);

  assign lt_c = (a < b);
  assign eq_c = (a == b);
  assign gt_c = (a > b);

endmodule

// File: rtl/serial_mag_cmp.sv
// Digit-serial MSB-first magnitude comparator with early termination,
// per-transaction signed mode, cascade inputs and valid/ready on both sides.
module serial_mag_cmp
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  input  logic                               is_signed,
  input  logic                               casc_lt,
  input  logic                               casc_eq,
  input  logic                               casc_gt,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               lt,
  output logic                               eq,
  output logic                               gt,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]   digits
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CNT_W = $clog2(NDIG + 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "serial_mag_cmp: WIDTH must be a nonzero multiple of DIGIT");
  end

  cmp_state_e                   state;
  logic [NDIG-1:0][DIGIT-1:0]   a_r;
  logic [NDIG-1:0][DIGIT-1:0]   b_r;
  logic [2:0]                   casc_r;
  logic [IDX_W-1:0]             idx;
  cmp_res_t                     res;
  logic                         accept;
  logic                         dig_lt;
  logic                         dig_eq;
  logic                         dig_gt;

  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  assign lt = res[2];
  assign eq = res[1];
  assign gt = res[0];

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // and it only ever lands in the top digit.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r    <= a ^ (is_signed ? MSB_MASK : '0);
      b_r    <= b ^ (is_signed ? MSB_MASK : '0);
      casc_r <= {casc_lt, casc_eq, casc_gt};
    end
  end

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .lt_c (dig_lt),
    .eq_c (dig_eq),
    .gt_c (dig_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      res       <= '0;
      digits    <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= IDX_W'(NDIG - 1);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!dig_eq) begin
            res       <= cmp_res_t'({dig_lt, dig_eq, dig_gt});
            digits    <= CNT_W'(NDIG - 32'(idx));
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx != '0) begin
            idx <= idx - IDX_W'(1);
          end else begin
            res       <= cascade_resolve(casc_r[2], casc_r[1], casc_r[0]);
            digits    <= CNT_W'(NDIG);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              idx   <= IDX_W'(NDIG - 1);
              state <= SCAN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed bench for serial_mag_cmp: 16/4 main instance plus an 8/8
// instance where every comparison finishes in one digit.
module tb_serial_mag_cmp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b;
  logic        is_signed, casc_lt, casc_eq, casc_gt;
  logic        lt, eq, gt;
  logic [2:0]  digits;

  logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready;
  logic [7:0]  w8_a, w8_b;
  logic        w8_is_signed, w8_casc_lt, w8_casc_eq, w8_casc_gt;
  logic        w8_lt, w8_eq, w8_gt;
  logic [0:0]  w8_digits;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_mag_cmp #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed),
    .casc_lt(casc_lt), .casc_eq(casc_eq), .casc_gt(casc_gt),
    .out_valid(out_valid), .out_ready(out_ready),
    .lt(lt), .eq(eq), .gt(gt), .digits(digits)
  );

  serial_mag_cmp #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .a(w8_a), .b(w8_b), .is_signed(w8_is_signed),
    .casc_lt(w8_casc_lt), .casc_eq(w8_casc_eq), .casc_gt(w8_casc_gt),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready),
    .lt(w8_lt), .eq(w8_eq), .gt(w8_gt), .digits(w8_digits)
  );

  // Present one transaction for exactly one edge (caller ensures in_ready).
  task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                      input logic s, input logic [2:0] casc);
    a = ta; b = tb; is_signed = s;
    {casc_lt, casc_eq, casc_gt} = casc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid; -1 if it never comes.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if ({out_valid, lt, eq, gt, digits} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000000", {out_valid, lt, eq, gt, digits});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_unsigned_lt();
    int lat;
    send(16'h1234, 16'h1235, 1'b0, 3'b000);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL scan_in_ready got %b want 0", in_ready); end
    wait_result(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL lt_latency got %0d want 4", lat); end
    checks++;
    if ({lt, eq, gt} !== 3'b100 || digits !== 3'd4) begin
      errors++; $display("FAIL lt_result got %b/%0d want 100/4", {lt, eq, gt}, digits);
    end
    pop();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL lt_pop got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed();
    int lat;
    send(16'h8000, 16'h7FFF, 1'b0, 3'b000);
    wait_result(lat);
    checks++;
    if (lat !== 1 || {lt, eq, gt} !== 3'b001 || digits !== 3'd1) begin
      errors++; $display("FAIL unsigned_msb got lat=%0d %b/%0d want 1 001/1", lat, {lt, eq, gt}, digits);
    end
    pop();
    send(16'h8000, 16'h7FFF, 1'b1, 3'b000);
    wait_result(lat);
    checks++;
    if (lat !== 1 || {lt, eq, gt} !== 3'b100 || digits !== 3'd1) begin
      errors++; $display("FAIL signed_msb got lat=%0d %b/%0d want 1 100/1", lat, {lt, eq, gt}, digits);
    end
    pop();
    // -1 vs -2 signed: 0x7FFF vs 0x7FFE after sign flip, differ in last digit
    send(16'hFFFF, 16'hFFFE, 1'b1, 3'b000);
    wait_result(lat);
    checks++;
    if (lat !== 4 || {lt, eq, gt} !== 3'b001 || digits !== 3'd4) begin
      errors++; $display("FAIL signed_neg got lat=%0d %b/%0d want 4 001/4", lat, {lt, eq, gt}, digits);
    end
    pop();
  endtask

  task automatic test_cascade();
    int lat;
    logic [2:0] casc_v [4] = '{3'b001, 3'b110, 3'b000, 3'b100};
    logic [2:0] exp_v  [4] = '{3'b001, 3'b010, 3'b010, 3'b100};
    for (int i = 0; i < 4; i++) begin
      send(16'hABCD, 16'hABCD, i[0], casc_v[i]);
      wait_result(lat);
      checks++;
      if (lat !== 4 || {lt, eq, gt} !== exp_v[i] || digits !== 3'd4) begin
        errors++; $display("FAIL cascade_%0d got lat=%0d %b/%0d want 4 %b/4",
                           i, lat, {lt, eq, gt}, digits, exp_v[i]);
      end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(16'h1234, 16'h1235, 1'b0, 3'b000);
    wait_result(lat);
    // Garbage offered while the result is held must not disturb it
    a = 16'h0000; b = 16'hFFFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || {lt, eq, gt} !== 3'b100 || digits !== 3'd4 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got v=%b %b/%0d rdy=%b want 1 100/4 rdy=0",
                           i, out_valid, {lt, eq, gt}, digits, in_ready);
      end
    end
    a = 16'h0001; b = 16'h0000; is_signed = 1'b0;
    {casc_lt, casc_eq, casc_gt} = 3'b000;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
    end
    wait_result(lat);
    checks++;
    if (lat !== 4 || {lt, eq, gt} !== 3'b001 || digits !== 3'd4) begin
      errors++; $display("FAIL b2b_result got lat=%0d %b/%0d want 4 001/4", lat, {lt, eq, gt}, digits);
    end
    pop();
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    send(16'h00F0, 16'h00F1, 1'b0, 3'b000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_scan_during got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_scan_release got %b want 1", in_ready); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_scan_no_result got %b want 0", out_valid); end
    send(16'h00F0, 16'h00F1, 1'b0, 3'b000);
    wait_result(lat);
    checks++;
    if (lat !== 4 || {lt, eq, gt} !== 3'b100 || digits !== 3'd4) begin
      errors++; $display("FAIL rst_scan_next got lat=%0d %b/%0d want 4 100/4", lat, {lt, eq, gt}, digits);
    end
    pop();
  endtask

  task automatic test_wide_digit();
    logic [7:0] va [3] = '{8'h80, 8'h80, 8'h5A};
    logic [7:0] vb [3] = '{8'h7F, 8'h7F, 8'h5A};
    logic       vs [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0] vc [3] = '{3'b000, 3'b000, 3'b100};
    logic [2:0] ve [3] = '{3'b001, 3'b100, 3'b100};
    int lat;
    for (int i = 0; i < 3; i++) begin
      w8_a = va[i]; w8_b = vb[i]; w8_is_signed = vs[i];
      {w8_casc_lt, w8_casc_eq, w8_casc_gt} = vc[i];
      w8_in_valid = 1'b1;
      @(posedge clk); #1;
      w8_in_valid = 1'b0;
      lat = -1;
      for (int j = 1; j <= 20; j++) begin
        @(posedge clk); #1;
        if (w8_out_valid) begin lat = j; break; end
      end
      checks++;
      if (lat !== 1 || {w8_lt, w8_eq, w8_gt} !== ve[i] || w8_digits !== 1'b1) begin
        errors++; $display("FAIL w8_%0d got lat=%0d %b/%0d want 1 %b/1",
                           i, lat, {w8_lt, w8_eq, w8_gt}, w8_digits, ve[i]);
      end
      w8_out_ready = 1'b1;
      @(posedge clk); #1;
      w8_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    casc_lt = 1'b0; casc_eq = 1'b0; casc_gt = 1'b0;
    w8_in_valid = 1'b0; w8_out_ready = 1'b0;
    w8_a = '0; w8_b = '0; w8_is_signed = 1'b0;
    w8_casc_lt = 1'b0; w8_casc_eq = 1'b0; w8_casc_gt = 1'b0;
    test_reset();
    test_unsigned_lt();
    test_signed();
    test_cascade();
    test_back_to_back();
    test_reset_mid_scan();
    test_wide_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

Parametrised digit-serial magnitude comparator, the sequential successor to our fixed-width 4-bit cascadable comparator slice. It compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, with early termination on the first differing digit. Signed or unsigned mode is selected per transaction, and 7485-style cascade inputs apply when the operands are equal. It sits between operand producers and consumers behind valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle. NDIG = WIDTH/DIGIT.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/control presented.
- in_ready  out  1  block can accept.
- a, b  in  WIDTH  operands.
- is_signed  in  1  1 = two's-complement compare.
- casc_lt, casc_eq, casc_gt  in  1 each  cascade inputs, used only when a == b.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- lt, eq, gt  out  1 each  one-hot result.
- digits  out  $clog2(NDIG+1)  number of digits examined (1..NDIG).

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, is_signed and the cascade inputs, set idx=NDIG-1, go to SCAN.
- SCAN: compare digit idx of a against digit idx of b.
  - In signed mode, invert the MSB of both operands for the top digit only.
  - Digits differ: register lt/gt and digits=NDIG-idx, go to DONE.
  - Digits equal and idx>0: decrement idx, stay in SCAN.
  - Digits equal and idx==0: resolve from the latched cascade inputs, digits=NDIG, go to DONE.
- Cascade priority is casc_eq > casc_lt > casc_gt. If all three are 0, the result is eq.
- DONE: out_valid=1, and lt/eq/gt/digits are held stable until out_valid&&out_ready.
  - On that handshake, if in_valid is also high, the new operands are accepted in the same cycle (in_ready = out_ready in DONE) and the FSM goes straight to SCAN. Otherwise it goes to IDLE.
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
- Inputs presented while in SCAN are ignored; in_ready is 0.
- Exactly one of lt/eq/gt is high whenever out_valid=1.

## Timing
- Reset values: state=IDLE, out_valid=0, lt=eq=gt=0, digits=0. in_ready is 0 while rst is high and 1 in the first cycle after it is released.
- rst asserted in any state aborts the operation. No result is emitted, and operand registers are don't-care.
- Accept at edge T. Digit comparisons happen at edges T+1..T+k, where k is the index from the MSB of the first differing digit, or NDIG if the operands are equal.
- out_valid rises after edge T+k. Accept-to-result latency is k cycles (min 1, max NDIG).
- Back-to-back throughput: one result per k+1 cycles. The DONE cycle overlaps with the next accept.
- Outputs are registered. No combinational path from a/b to lt/eq/gt.
- in_ready depends combinationally on out_ready, and on nothing else external.

## Structure
- Package cmp_pkg:
  - state enum {IDLE, SCAN, DONE};
  - 3-bit one-hot result typedef with constants CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001;
  - function cascade_resolve(lt,eq,gt) implementing the priority rule.
- Sub-module digit_cmp:
  - parametrised by DIGIT;
  - combinational, producing lt/eq/gt for one digit pair;
  - generalises the existing fixed-width slice;
  - one instance in serial_mag_cmp, fed by a digit mux on idx.
- Elaboration check: WIDTH % DIGIT != 0 or DIGIT < 1 is a fatal error.

## Test plan
- WIDTH=16, DIGIT=4, unsigned, a=0x1234, b=0x1235 -> lt=1, digits=4, out_valid 4 cycles after accept.
- a=0x8000, b=0x7FFF:
  - unsigned -> gt=1, digits=1, latency 1;
  - signed -> lt=1, digits=1.
- a=b=0xABCD:
  - casc_gt=1 only -> gt=1, digits=4;
  - casc_eq=1, casc_lt=1 -> eq=1;
  - all cascade inputs 0 -> eq=1.
- Result handshake:
  - out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0;
  - then out_ready=1 with in_valid=1 (a=0x0001, b=0x0000) -> new accept in the same cycle, gt=1 after 4 cycles.
- Reset mid-SCAN:
  - rst at the second SCAN cycle of a=0x00F0, b=0x00F1 -> out_valid stays 0, in_ready=1 after release, the next transaction completes correctly.
- Parameter sweep: WIDTH=8/DIGIT=8 -> latency always 1; WIDTH=12/DIGIT=5 -> elaboration failure.
